// File: rtl/cpu_pkg.sv
// cpu_pkg: shared widths, opcode and execute-stage state types.
package cpu_pkg;
    localparam int DATA_W = 16;
    localparam int ADDR_W = 4;
    typedef enum logic [3:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_AND = 4'd2,
        OP_OR  = 4'd3,
        OP_XOR = 4'd4,
        OP_SHL = 4'd5,
        OP_SHR = 4'd6,
        OP_MUL = 4'd7,
        OP_MOV = 4'd8
    } opcode_e;
    typedef enum logic {EX_IDLE, EX_MUL} ex_state_e;
endpackage

// File: rtl/mul_seq.sv
// mul_seq: W-iteration shift-add unsigned multiplier; done marks the final iteration.
module mul_seq #(
    parameter int W = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic           run,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic           done,
    output logic [2*W-1:0] product
);
    localparam int CW = $clog2(W);
    logic [2*W-1:0] r_acc;
    logic [2*W-1:0] r_mcand;
    logic [W-1:0]   r_mplier;
    logic [CW-1:0]  r_cnt;
    // product is the accumulator after the current iteration, so it is final when done
    assign product = r_acc + (r_mplier[0] ? r_mcand : '0);
    assign done    = run && (r_cnt == CW'(W - 1));
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
        end else if (start) begin
            r_acc    <= '0;
            r_mcand  <= {{W{1'b0}}, a};
            r_mplier <= b;
            r_cnt    <= '0;
        end else if (run) begin
            r_acc    <= product;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + 1'b1;
        end
    end
endmodule

// File: rtl/alu_exec.sv
// alu_exec: execute stage with single-cycle ALU, sequential multiply and
// register-file writeback; in_ready stalls issue while a multiply runs.
module alu_exec #(
    parameter int DATA_W = cpu_pkg::DATA_W,
    parameter int ADDR_W = cpu_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        opcode,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [DATA_W-1:0] op_a,
    input  logic [DATA_W-1:0] op_b,
    output logic              wb_we,
    output logic [ADDR_W-1:0] wb_addr,
    output logic [DATA_W-1:0] wb_data,
    output logic              flag_z,
    output logic              flag_c
);
    import cpu_pkg::*;
    localparam int SW = $clog2(DATA_W);
    ex_state_e           r_state;
    ex_state_e           w_next;
    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [ADDR_W-1:0]   r_dst;
    logic [DATA_W-1:0]   r_data;
    logic                r_z;
    logic                r_c;
    opcode_e             w_op;
    logic                w_accept;
    logic                w_start;
    logic                w_done;
    logic [2*DATA_W-1:0] w_prod;
    logic [DATA_W-1:0]   w_res;
    logic                w_c;
    logic                w_we;
    logic                w_upd;
    logic [SW-1:0]       w_sh;
    assign w_op     = opcode_e'(opcode);
    assign in_ready = (r_state == EX_IDLE);
    assign w_accept = in_valid && in_ready;
    assign w_start  = w_accept && (w_op == OP_MUL);
    assign w_sh     = op_b[SW-1:0];
    mul_seq #(.W(DATA_W)) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (w_start),
        .run     (r_state == EX_MUL),
        .a       (op_a),
        .b       (op_b),
        .done    (w_done),
        .product (w_prod)
    );
    always_comb begin
        w_next = (r_state == EX_IDLE) ? (w_start ? EX_MUL : EX_IDLE) : (w_done ? EX_IDLE : EX_MUL);
    end
    always_ff @(posedge clk) begin
        if (rst) r_state <= EX_IDLE;
        else     r_state <= w_next;
    end
    // shifts carry one extra bit so the last bit shifted out lands in w_c
    always_comb begin
        w_res = '0;
        w_c   = 1'b0;
        w_we  = 1'b1;
        w_upd = 1'b1;
        case (w_op)
            OP_ADD:  {w_c, w_res} = {1'b0, op_a} + {1'b0, op_b};
            OP_SUB:  {w_c, w_res} = {1'b0, op_a} - {1'b0, op_b};
            OP_AND:  w_res = op_a & op_b;
            OP_OR:   w_res = op_a | op_b;
            OP_XOR:  w_res = op_a ^ op_b;
            OP_SHL:  {w_c, w_res} = {1'b0, op_a} << w_sh;
            OP_SHR:  {w_res, w_c} = {op_a, 1'b0} >> w_sh;
            OP_MOV:  begin w_res = op_b; w_upd = 1'b0; end
            default: begin w_we = 1'b0; w_upd = 1'b0; end
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_we   <= 1'b0;
            r_addr <= '0;
            r_data <= '0;
            r_z    <= 1'b0;
            r_c    <= 1'b0;
            r_dst  <= '0;
        end else begin
            r_we <= 1'b0;
            if (w_done) begin
                r_we   <= 1'b1;
                r_addr <= r_dst;
                r_data <= w_prod[DATA_W-1:0];
                r_z    <= (w_prod[DATA_W-1:0] == '0);
                r_c    <= |w_prod[2*DATA_W-1:DATA_W];
            end else if (w_accept) begin
                r_dst <= dst_addr;
                if (w_we) begin
                    r_we   <= 1'b1;
                    r_addr <= dst_addr;
                    r_data <= w_res;
                end
                if (w_upd) begin
                    r_z <= (w_res == '0);
                    r_c <= w_c;
                end
            end
        end
    end
    assign wb_we   = r_we;
    assign wb_addr = r_addr;
    assign wb_data = r_data;
    assign flag_z  = r_z;
    assign flag_c  = r_c;
endmodule

// File: tb/tb_alu_exec.sv
// tb_alu_exec: directed table, multiply/reset corner sequences and random ops vs a reference model.
module tb_alu_exec;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [3:0]  opcode = '0;
    logic [3:0]  dst_addr = '0;
    logic [15:0] op_a = '0;
    logic [15:0] op_b = '0;
    logic        in_ready, wb_we, flag_z, flag_c;
    logic [3:0]  wb_addr;
    logic [15:0] wb_data;
    int checks = 0;
    int failures = 0;
    logic        mz, mc;
    logic [3:0]  ma;
    logic [15:0] md;

    always #5 clk = ~clk;

    alu_exec dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .dst_addr(dst_addr), .op_a(op_a), .op_b(op_b),
        .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
        .flag_z(flag_z), .flag_c(flag_c)
    );

    typedef struct {
        logic [3:0]  op;
        logic [15:0] a, b;
        logic [3:0]  dst;
        logic        we;
        logic [3:0]  addr;
        logic [15:0] data;
        logic        z, c;
    } vec_t;
    vec_t tbl[13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        in_valid = 1'b0;
        step;
        rst = 1'b0;
        mz = 0; mc = 0; ma = 0; md = 0;
    endtask

    // reference: plain integer arithmetic on the architectural rules
    task automatic model(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                         input logic [3:0] dst, output logic we);
        int unsigned ua, ub, s, r;
        bit upd, c;
        ua = a; ub = b; s = b[3:0]; upd = 1; c = 0; we = 1;
        case (op)
            0: begin r = ua + ub; c = r > 32'hFFFF; end
            1: begin r = ua - ub; c = ua < ub; end
            2: r = ua & ub;
            3: r = ua | ub;
            4: r = ua ^ ub;
            5: begin r = ua << s; c = (s != 0) && (((ua >> (16 - s)) & 1) != 0); end
            6: begin r = ua >> s; c = (s != 0) && (((ua >> (s - 1)) & 1) != 0); end
            7: begin r = ua * ub; c = (r >> 16) != 0; end
            8: begin r = ub; upd = 0; end
            default: begin r = 0; we = 0; upd = 0; end
        endcase
        if (upd) begin mz = (r[15:0] == 0); mc = c; end
        if (we) begin ma = dst; md = r[15:0]; end
    endtask

    task automatic run_op(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                          input logic [3:0] dst, input string tag);
        logic we;
        int n;
        model(op, a, b, dst, we);
        opcode = op; op_a = a; op_b = b; dst_addr = dst; in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 40) begin step; n++; end
        if (!in_ready) check({tag, " accept timeout"}, {31'b0, in_ready}, 1);
        step;
        in_valid = 1'b0;
        opcode = 4'($urandom); op_a = 16'($urandom); op_b = 16'($urandom); dst_addr = 4'($urandom);
        if (op == 4'd7) begin
            n = 0;
            while (!wb_we && n < 20) begin step; n++; end
            check({tag, " mul latency"}, n, 16);
        end
        check({tag, " we"},   {31'b0, wb_we}, {31'b0, we});
        check({tag, " addr"}, {28'b0, wb_addr}, {28'b0, ma});
        check({tag, " data"}, {16'b0, wb_data}, {16'b0, md});
        check({tag, " z"},    {31'b0, flag_z}, {31'b0, mz});
        check({tag, " c"},    {31'b0, flag_c}, {31'b0, mc});
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, ones;
        logic [3:0] rop;
        tbl[0]  = '{4'h0, 16'hFFFF, 16'h0001, 4'h3, 1, 4'h3, 16'h0000, 1, 1};
        tbl[1]  = '{4'h8, 16'h0000, 16'h1234, 4'h4, 1, 4'h4, 16'h1234, 1, 1};
        tbl[2]  = '{4'hF, 16'h1111, 16'h2222, 4'h7, 0, 4'h4, 16'h1234, 1, 1};
        tbl[3]  = '{4'h1, 16'h0005, 16'h0007, 4'h1, 1, 4'h1, 16'hFFFE, 0, 1};
        tbl[4]  = '{4'h6, 16'h8001, 16'h0001, 4'h2, 1, 4'h2, 16'h4000, 0, 1};
        tbl[5]  = '{4'h2, 16'hF0F0, 16'h0F0F, 4'h6, 1, 4'h6, 16'h0000, 1, 0};
        tbl[6]  = '{4'h3, 16'hF0F0, 16'h0F0F, 4'h7, 1, 4'h7, 16'hFFFF, 0, 0};
        tbl[7]  = '{4'h4, 16'hAAAA, 16'hAAAA, 4'h8, 1, 4'h8, 16'h0000, 1, 0};
        tbl[8]  = '{4'h5, 16'h8001, 16'h0001, 4'h9, 1, 4'h9, 16'h0002, 0, 1};
        tbl[9]  = '{4'h5, 16'hFFFF, 16'h0010, 4'hA, 1, 4'hA, 16'hFFFF, 0, 0};
        tbl[10] = '{4'h6, 16'h0001, 16'h0001, 4'hB, 1, 4'hB, 16'h0000, 1, 1};
        tbl[11] = '{4'h0, 16'h7FFF, 16'h0001, 4'hC, 1, 4'hC, 16'h8000, 0, 0};
        tbl[12] = '{4'h9, 16'h0000, 16'h0000, 4'hD, 0, 4'hC, 16'h8000, 0, 0};

        step;
        do_reset;
        check("reset we",    {31'b0, wb_we}, 0);
        check("reset addr",  {28'b0, wb_addr}, 0);
        check("reset data",  {16'b0, wb_data}, 0);
        check("reset z",     {31'b0, flag_z}, 0);
        check("reset c",     {31'b0, flag_c}, 0);
        check("reset ready", {31'b0, in_ready}, 1);

        // back-to-back single-cycle ops, in_valid held high throughout
        for (int i = 0; i < 13; i++) begin
            in_valid = 1'b1; opcode = tbl[i].op; op_a = tbl[i].a; op_b = tbl[i].b; dst_addr = tbl[i].dst;
            step;
            check($sformatf("vec%0d we", i),   {31'b0, wb_we},   {31'b0, tbl[i].we});
            check($sformatf("vec%0d addr", i), {28'b0, wb_addr}, {28'b0, tbl[i].addr});
            check($sformatf("vec%0d data", i), {16'b0, wb_data}, {16'b0, tbl[i].data});
            check($sformatf("vec%0d z", i),    {31'b0, flag_z},  {31'b0, tbl[i].z});
            check($sformatf("vec%0d c", i),    {31'b0, flag_c},  {31'b0, tbl[i].c});
        end
        in_valid = 1'b0;
        step;
        check("idle we", {31'b0, wb_we}, 0);
        check("idle data hold", {16'b0, wb_data}, 16'h8000);

        // MUL with an ADD waiting behind it
        in_valid = 1'b1; opcode = 4'd7; op_a = 16'h0123; op_b = 16'h0100; dst_addr = 4'd5;
        step;
        opcode = 4'd0; op_a = 16'h0001; op_b = 16'h0002; dst_addr = 4'd6;
        n = 0; ones = 0;
        for (int k = 0; k < 16; k++) begin
            if (!in_ready) n++;
            if (wb_we) ones++;
            step;
        end
        check("mul stall cycles", n, 16);
        check("mul early we", ones, 0);
        check("mul we",    {31'b0, wb_we}, 1);
        check("mul addr",  {28'b0, wb_addr}, 5);
        check("mul data",  {16'b0, wb_data}, 16'h2300);
        check("mul c",     {31'b0, flag_c}, 1);
        check("mul z",     {31'b0, flag_z}, 0);
        check("mul ready", {31'b0, in_ready}, 1);
        step;
        in_valid = 1'b0;
        check("add after mul we",   {31'b0, wb_we}, 1);
        check("add after mul addr", {28'b0, wb_addr}, 6);
        check("add after mul data", {16'b0, wb_data}, 16'h0003);

        do_reset;
        run_op(4'd7, 16'h00FF, 16'h00FF, 4'd2, "mul ff");
        run_op(4'd0, 16'hFFFF, 16'h0001, 4'd3, "pre-abort add");

        // reset mid-multiply aborts without writeback
        in_valid = 1'b1; opcode = 4'd7; op_a = 16'hFFFF; op_b = 16'hFFFF; dst_addr = 4'd9;
        step;
        in_valid = 1'b0;
        repeat (8) step;
        rst = 1'b1;
        step;
        rst = 1'b0;
        check("abort we",    {31'b0, wb_we}, 0);
        check("abort z",     {31'b0, flag_z}, 0);
        check("abort c",     {31'b0, flag_c}, 0);
        check("abort ready", {31'b0, in_ready}, 1);
        ones = 0;
        for (int k = 0; k < 12; k++) begin
            step;
            if (wb_we) ones++;
        end
        check("abort no late we", ones, 0);

        // reset wins over a simultaneous accept
        mz = 0; mc = 0; ma = 0; md = 0;
        run_op(4'd0, 16'hFFFF, 16'h0001, 4'd3, "pre-prio add");
        in_valid = 1'b1; opcode = 4'd0; op_a = 16'hFFFF; op_b = 16'h0001; dst_addr = 4'd3; rst = 1'b1;
        step;
        rst = 1'b0; in_valid = 1'b0;
        check("prio we", {31'b0, wb_we}, 0);
        check("prio z",  {31'b0, flag_z}, 0);
        step;
        check("prio no late we", {31'b0, wb_we}, 0);

        do_reset;
        for (int i = 0; i < 300; i++) begin
            rop = 4'($urandom_range(0, 15));
            run_op(rop, ($urandom_range(0, 5) == 0) ? 16'h0000 : 16'($urandom),
                   ($urandom_range(0, 5) == 0) ? 16'h0000 : 16'($urandom),
                   4'($urandom), $sformatf("rnd%0d op%0d", i, rop));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
